gf_poly_mult: RTL and testbench

Combinational-core, output-registered multiplier for polynomials whose coefficients lie in GF(2^SIZE). It is the default GF(2^8) configuration used by the Reed-Solomon encode/decode datapath. It takes two degree-n polynomials packed as flat vectors and returns the degree-2n product polynomial, also packed flat. Per-row partial products are exported for debug.

---
 rtl/gf_pkg.sv | 11 +
 rtl/gf_mul.sv | 34 +++
 rtl/gf_poly_mult.sv | 78 +++++++
 tb/tb_gf_poly_mult.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^8) field definitions for the Reed-Solomon datapath.
// Holds the default coefficient width, the primitive polynomial and the coefficient type.
package gf_pkg;

    localparam int GF_M = 255;
    localparam int GF_SIZE = 8;
    localparam logic [GF_SIZE:0] GF_PRIM = 9'h11D;

    typedef logic [GF_SIZE-1:0] coef_t;

endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^SIZE) coefficient multiplier.
// Shift-and-add over the bits of b, reducing the running multiple of a by PRIM on overflow.
module gf_mul
    import gf_pkg::*;
#(
    parameter int SIZE = GF_SIZE,
    parameter logic [SIZE:0] PRIM = GF_PRIM
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] p
);

    logic [SIZE-1:0] acc;
    logic [SIZE-1:0] shifted;

    always_comb begin
        acc = '0;
        shifted = a;
        for (int i = 0; i < SIZE; i++) begin
            if (b[i]) begin
                acc = acc ^ shifted;
            end
            // Multiply by x, folding the bit that leaves the field back in via PRIM
            if (shifted[SIZE-1]) begin
                shifted = {shifted[SIZE-2:0], 1'b0} ^ PRIM[SIZE-1:0];
            end else begin
                shifted = {shifted[SIZE-2:0], 1'b0};
            end
        end
        p = acc;
    end

endmodule

// File: rtl/gf_poly_mult.sv
// Polynomial multiplier over GF(2^SIZE): combinational partial-product rows and XOR tree,
// with the product and the first three rows registered (one cycle latency, one pair per cycle).
module gf_poly_mult
    import gf_pkg::*;
#(
    parameter int m = GF_M,
    parameter int SIZE = $clog2(m),
    parameter int n = 2,
    parameter int flat_size = (n + 1) * SIZE,
    parameter int large_array = 2 * n,
    parameter int large_array_size = (large_array + 1) * SIZE,
    parameter logic [SIZE:0] PRIM = GF_PRIM
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [flat_size-1:0]        flat_p,
    input  logic [flat_size-1:0]        flat_q,
    output logic [large_array_size-1:0] flat_z,
    output logic [large_array_size-1:0] out0,
    output logic [large_array_size-1:0] out1,
    output logic [large_array_size-1:0] out2
);

    localparam int TERMS = (n + 1) * (n + 1);

    logic [SIZE-1:0]             prod [TERMS];
    logic [large_array_size-1:0] no_highz [n+1];
    logic [large_array_size-1:0] z_next;
    logic [large_array_size-1:0] row_sel [3];

    for (genvar i = 0; i <= n; i++) begin : g_row
        for (genvar j = 0; j <= n; j++) begin : g_col
            gf_mul #(
                .SIZE (SIZE),
                .PRIM (PRIM)
            ) u_gf_mul (
                .a (flat_p[i*SIZE +: SIZE]),
                .b (flat_q[j*SIZE +: SIZE]),
                .p (prod[i*(n+1)+j])
            );
        end
    end

    // Row i places p_i*q_j at coefficient i+j; the product is the XOR of all rows
    always_comb begin
        z_next = '0;
        for (int i = 0; i <= n; i++) begin
            no_highz[i] = '0;
            for (int j = 0; j <= n; j++) begin
                no_highz[i][(i+j)*SIZE +: SIZE] = prod[i*(n+1)+j];
            end
            z_next = z_next ^ no_highz[i];
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_sel
        if (k <= n) begin : g_used
            assign row_sel[k] = no_highz[k];
        end else begin : g_tied
            assign row_sel[k] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flat_z <= '0;
            out0   <= '0;
            out1   <= '0;
            out2   <= '0;
        end else begin
            flat_z <= z_next;
            out0   <= row_sel[0];
            out1   <= row_sel[1];
            out2   <= row_sel[2];
        end
    end

endmodule

// File: tb/tb_gf_poly_mult.sv
// Bench for gf_poly_mult: directed and random operand pairs feed an expectation queue;
// a monitor pops one entry per cycle and compares all registered outputs.
module tb_gf_poly_mult;

    logic        clk;
    logic        rst;
    logic [23:0] flat_p;
    logic [23:0] flat_q;
    logic [39:0] flat_z;
    logic [39:0] out0;
    logic [39:0] out1;
    logic [39:0] out2;

    typedef struct {
        string       name;
        logic [39:0] z;
        logic [39:0] o0;
        logic [39:0] o1;
        logic [39:0] o2;
    } exp_t;

    exp_t exp_q[$];
    int   total_checks = 0;
    int   passed_checks = 0;

    gf_poly_mult dut (
        .clk    (clk),
        .rst    (rst),
        .flat_p (flat_p),
        .flat_q (flat_q),
        .flat_z (flat_z),
        .out0   (out0),
        .out1   (out1),
        .out2   (out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
        total_checks++;
        if (act === req) begin
            passed_checks++;
        end else begin
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference multiply: full carry-less product, then long division by 0x11D
    function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) c = c ^ (15'(a) << i);
        end
        for (int k = 14; k >= 8; k--) begin
            if (c[k]) c = c ^ (15'h11D << (k - 8));
        end
        return c[7:0];
    endfunction

    function automatic exp_t ref_model(input string name, input logic [23:0] p, input logic [23:0] q);
        exp_t        e;
        logic [39:0] rows [3];
        e.name = name;
        e.z = '0;
        for (int i = 0; i < 3; i++) begin
            rows[i] = '0;
            for (int j = 0; j < 3; j++) begin
                rows[i][(i+j)*8 +: 8] = ref_gmul(p[i*8 +: 8], q[j*8 +: 8]);
            end
            e.z = e.z ^ rows[i];
        end
        e.o0 = rows[0];
        e.o1 = rows[1];
        e.o2 = rows[2];
        return e;
    endfunction

    task automatic issue(input string name, input logic r, input logic [23:0] p, input logic [23:0] q,
                         input logic [39:0] z, input logic [39:0] o0, input logic [39:0] o1,
                         input logic [39:0] o2);
        exp_t e;
        @(negedge clk);
        rst = r;
        flat_p = p;
        flat_q = q;
        e.name = name;
        e.z = z;
        e.o0 = o0;
        e.o1 = o1;
        e.o2 = o2;
        exp_q.push_back(e);
    endtask

    task automatic issue_model(input string name, input logic [23:0] p, input logic [23:0] q);
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        flat_p = p;
        flat_q = q;
        e = ref_model(name, p, q);
        exp_q.push_back(e);
    endtask

    // Monitor: one result per edge, sampled just after it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, "_z"}, flat_z, e.z);
                chk({e.name, "_out0"}, out0, e.o0);
                chk({e.name, "_out1"}, out1, e.o1);
                chk({e.name, "_out2"}, out2, e.o2);
            end
        end
    end

    initial begin
        logic [23:0] rp;
        logic [23:0] rq;
        rst = 1'b1;
        flat_p = '0;
        flat_q = '0;

        issue("reset0", 1'b1, 24'h040105, 24'h020003, '0, '0, '0, '0);
        issue("reset1", 1'b1, 24'h040105, 24'h020003, '0, '0, '0, '0);
        issue("default", 1'b0, 24'h040105, 24'h020003,
              40'h080206030F, 40'h00000A000F, 40'h0002000300, 40'h08000C0000);
        issue("reduce", 1'b0, 24'h000080, 24'h000002,
              40'h000000001D, 40'h000000001D, '0, '0);
        issue("reduce_swap", 1'b0, 24'h000002, 24'h000080,
              40'h000000001D, 40'h000000001D, '0, '0);
        issue("identity", 1'b0, 24'h000001, 24'hA5B6C7,
              40'h0000A5B6C7, 40'h0000A5B6C7, '0, '0);
        issue("shift_x2", 1'b0, 24'h010000, 24'h000001,
              40'h0000010000, '0, '0, 40'h0000010000);
        issue("zero_p", 1'b0, 24'h000000, 24'hFFEE77, '0, '0, '0, '0);
        issue("zero_q", 1'b0, 24'h9A3C11, 24'h000000, '0, '0, '0, '0);
        issue("mid_reset", 1'b1, 24'h040105, 24'h020003, '0, '0, '0, '0);
        issue("after_reset", 1'b0, 24'h040105, 24'h020003,
              40'h080206030F, 40'h00000A000F, 40'h0002000300, 40'h08000C0000);

        for (int k = 0; k < 40; k++) begin
            rp = 24'($urandom);
            rq = 24'($urandom);
            issue_model($sformatf("rand%0d", k), rp, rq);
        end
        issue_model("all_ff", 24'hFFFFFF, 24'hFFFFFF);

        @(posedge clk);
        #2;
        total_checks++;
        if (exp_q.size() == 0) begin
            passed_checks++;
        end else begin
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
